// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller for the execute stage.
// Branches from issue queue up in a small FIFO and resolve one per cycle.
// A mispredict redirects the front end, squashes the younger buffered
// branches and opens a fixed-length flush window.

package branch_resolve_pkg;
    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_op_e;

    typedef struct packed {
        branch_op_e  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pred_taken;
        logic [31:0] pred_target;
    } br_entry_t;
endpackage

// Branch condition evaluation; encodings outside the enum resolve as not-taken.
module branch_gen
    import branch_resolve_pkg::*;
(
    input  branch_op_e  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        taken_o
);
    // Compare operands according to the branch condition
    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            BR_BEQ:  taken_o = (rs1_i == rs2_i);
            BR_BNE:  taken_o = (rs1_i != rs2_i);
            BR_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
            BR_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            BR_BLTU: taken_o = (rs1_i <  rs2_i);
            BR_BGEU: taken_o = (rs1_i >= rs2_i);
            default: taken_o = 1'b0;
        endcase
    end
endmodule

// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | accepting branches, popping/resolving the FIFO head per edge
// ST_FLUSH | post-mispredict window: no accepts, no pops, timer counting
module branch_resolve_ctrl
    import branch_resolve_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              br_valid_i,
    output logic              br_ready_o,
    input  branch_op_e        br_op_i,
    input  logic [31:0]       rs1_data_i,
    input  logic [31:0]       rs2_data_i,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       imm_i,
    input  logic              pred_taken_i,
    input  logic [31:0]       pred_target_i,
    output logic              res_valid_o,
    output logic              taken_o,
    output logic              mispredict_o,
    output logic              redirect_valid_o,
    output logic [31:0]       redirect_pc_o,
    output logic              flush_o,
    output logic [CNT_W-1:0]  mispredict_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [FW-1:0]    flush_cnt_q, flush_cnt_d;

    br_entry_t        mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic             res_valid_q, taken_q, mispredict_q, redirect_valid_q;
    logic [31:0]      redirect_pc_q;
    logic [CNT_W-1:0] mis_cnt_q;

    br_entry_t        push_entry, head;
    logic             push, pop, mispop;
    logic             head_taken, mispredict;
    logic [31:0]      seq_pc, actual_next, pred_next;

    assign push_entry = '{op:          br_op_i,
                          rs1:         rs1_data_i,
                          rs2:         rs2_data_i,
                          pc:          pc_i,
                          imm:         imm_i,
                          pred_taken:  pred_taken_i,
                          pred_target: pred_target_i};

    // Ready depends only on state and occupancy, never on br_valid_i
    assign br_ready_o = (state_q == ST_RUN) && (count_q < DEPTH_C);
    assign push       = br_valid_i && br_ready_o;
    assign pop        = (state_q == ST_RUN) && (count_q != '0);

    assign head = mem_q[rd_ptr_q];

    branch_gen u_branch_gen (
        .op_i    (head.op),
        .rs1_i   (head.rs1),
        .rs2_i   (head.rs2),
        .taken_o (head_taken)
    );

    assign seq_pc      = head.pc + 32'd4;
    assign actual_next = head_taken ? (head.pc + head.imm) : seq_pc;
    assign pred_next   = head.pred_taken ? head.pred_target : seq_pc;
    assign mispredict  = (actual_next != pred_next);
    assign mispop      = pop && mispredict;

    // FIFO pointers and occupancy; a mispredicting pop empties the FIFO and drops any same-edge push
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (mispop) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are only read while count is non-zero, so no reset
    always_ff @(posedge clk_i) begin
        if (push && !mispop) mem_q[wr_ptr_q] <= push_entry;
    end

    // Next state and flush-window down-counter
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mispop) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end
            default: begin
                if (flush_cnt_q == '0) state_d = ST_RUN;
                else                   flush_cnt_d = flush_cnt_q - 1'b1;
            end
        endcase
    end

    // State and flush counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Resolution result, redirect pulse and saturating mispredict count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_q      <= 1'b0;
            taken_q          <= 1'b0;
            mispredict_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            mis_cnt_q        <= '0;
        end else begin
            res_valid_q      <= pop;
            redirect_valid_q <= mispop;
            if (pop) begin
                taken_q       <= head_taken;
                mispredict_q  <= mispredict;
                redirect_pc_q <= actual_next;
            end
            if (mispop && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 1'b1;
        end
    end

    assign res_valid_o      = res_valid_q;
    assign taken_o          = taken_q;
    assign mispredict_o     = mispredict_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign flush_o          = (state_q == ST_FLUSH);
    assign mispredict_cnt_o = mis_cnt_q;
endmodule
